// File: rtl/ram_word_ctrl.sv
// ram_word_ctrl: 32-bit word access over a 64x8 byte RAM, four byte cycles per request.
// Optional alignment check enabled by defining RAM_CTRL_ALIGN_CHECK_EN.
module ram_word_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [5:0]  ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        RespErr,
    output logic [5:0]  MemReadAddress,
    output logic        MemReadEn,
    input  logic [7:0]  MemReadData,
    output logic [5:0]  MemWriteAddress,
    output logic [7:0]  MemWriteData,
    output logic        MemWriteEn
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        XFER0 = 3'd1,
        XFER1 = 3'd2,
        XFER2 = 3'd3,
        XFER3 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        wr_q;
    logic [5:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] shift_q;
    logic [31:0] rdata_q;
    logic        xfer;
    logic [1:0]  k;
    logic [5:0]  byte_addr;
    logic [7:0]  wbyte;
    logic        accept;

`ifdef RAM_CTRL_ALIGN_CHECK_EN
    logic err_q;
    logic misaligned;
    assign misaligned = (ReqAddr[1:0] != 2'b00);
`endif

    assign accept    = (state == IDLE) && ReqValid;
    assign byte_addr = addr_q + {4'b0000, k};
    assign RespData  = rdata_q;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: misaligned requests (when checked) skip straight to DONE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (ReqValid) begin
`ifdef RAM_CTRL_ALIGN_CHECK_EN
                    state_next = misaligned ? DONE : XFER0;
`else
                    state_next = XFER0;
`endif
                end
            end
            XFER0:   state_next = XFER1;
            XFER1:   state_next = XFER2;
            XFER2:   state_next = XFER3;
            XFER3:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, load byte assembly and load result register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_q    <= 1'b0;
            addr_q  <= 6'd0;
            wdata_q <= 32'd0;
            shift_q <= 32'd0;
            rdata_q <= 32'd0;
`ifdef RAM_CTRL_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                wr_q    <= ReqWrite;
                addr_q  <= ReqAddr;
                wdata_q <= ReqWData;
`ifdef RAM_CTRL_ALIGN_CHECK_EN
                err_q   <= misaligned;
`endif
            end
            if (xfer && !wr_q) begin
                unique case (k)
                    2'd0: shift_q[31:24] <= MemReadData;
                    2'd1: shift_q[23:16] <= MemReadData;
                    2'd2: shift_q[15:8]  <= MemReadData;
                    2'd3: shift_q[7:0]   <= MemReadData;
                    default: ;
                endcase
            end
            if ((state == XFER3) && !wr_q) begin
                rdata_q <= {shift_q[31:8], MemReadData};
            end
        end
    end

    // Byte-cycle decode: which byte of the word this state handles
    always_comb begin
        xfer = 1'b0;
        k    = 2'd0;
        unique case (state)
            XFER0: begin xfer = 1'b1; k = 2'd0; end
            XFER1: begin xfer = 1'b1; k = 2'd1; end
            XFER2: begin xfer = 1'b1; k = 2'd2; end
            XFER3: begin xfer = 1'b1; k = 2'd3; end
            default: begin xfer = 1'b0; k = 2'd0; end
        endcase
    end

    // Big-endian byte select from the latched store word
    always_comb begin
        wbyte = 8'd0;
        unique case (k)
            2'd0: wbyte = wdata_q[31:24];
            2'd1: wbyte = wdata_q[23:16];
            2'd2: wbyte = wdata_q[15:8];
            2'd3: wbyte = wdata_q[7:0];
            default: wbyte = 8'd0;
        endcase
    end

    // Outputs decoded from registered state only; memory pins idle at zero
    always_comb begin
        ReqReady        = (state == IDLE);
        RespValid       = (state == DONE);
        MemReadEn       = 1'b0;
        MemReadAddress  = 6'd0;
        MemWriteEn      = 1'b0;
        MemWriteAddress = 6'd0;
        MemWriteData    = 8'd0;
        if (xfer && wr_q) begin
            MemWriteEn      = 1'b1;
            MemWriteAddress = byte_addr;
            MemWriteData    = wbyte;
        end
        if (xfer && !wr_q) begin
            MemReadEn      = 1'b1;
            MemReadAddress = byte_addr;
        end
    end

`ifdef RAM_CTRL_ALIGN_CHECK_EN
    assign RespErr = (state == DONE) && err_q;
`else
    assign RespErr = 1'b0;
`endif

endmodule

// File: tb/tb_ram_word_ctrl.sv
// Scoreboard bench for ram_word_ctrl with a behavioural 64x8 RAM.
// Directed vectors; expected responses queued at accept, checked by a monitor.
module tb_ram_word_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqWrite;
    logic [5:0]  ReqAddr;
    logic [31:0] ReqWData;
    logic        ReqReady;
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespErr;
    logic [5:0]  MemReadAddress;
    logic        MemReadEn;
    logic [7:0]  MemReadData;
    logic [5:0]  MemWriteAddress;
    logic [7:0]  MemWriteData;
    logic        MemWriteEn;

    ram_word_ctrl dut (
        .Clk(Clk),
        .Reset(Reset),
        .ReqValid(ReqValid),
        .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr),
        .ReqWData(ReqWData),
        .ReqReady(ReqReady),
        .RespValid(RespValid),
        .RespData(RespData),
        .RespErr(RespErr),
        .MemReadAddress(MemReadAddress),
        .MemReadEn(MemReadEn),
        .MemReadData(MemReadData),
        .MemWriteAddress(MemWriteAddress),
        .MemWriteData(MemWriteData),
        .MemWriteEn(MemWriteEn)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    int   acc1;
    int   acc2;
    logic [7:0] ram [64];

    // RAM model: combinational read, write on the rising edge, cleared by Reset
    assign MemReadData = MemReadEn ? ram[MemReadAddress] : 8'h00;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= 8'h00;
        end else if (MemWriteEn) begin
            ram[MemWriteAddress] <= MemWriteData;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: counts RAM enables and scores every response
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                if (MemWriteEn) wr_cnt++;
                if (MemReadEn)  rd_cnt++;
                if (RespValid) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_resp: got RespValid=1 expected 0");
                    end else begin
                        mon_e = sb.pop_front();
                        chk("resp_data", RespData, mon_e.data);
                        chk("resp_err", {31'd0, RespErr}, {31'd0, mon_e.err});
                        chk("resp_cycle", cyc, mon_e.cyc);
                        chk("done_enables", {30'd0, MemWriteEn, MemReadEn}, 32'd0);
                    end
                end
            end
        end
    end

    task automatic wait_resp();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    // Issue one request, queue its expected response, wait for completion
    task automatic req(input logic w, input logic [5:0] a, input logic [31:0] d,
                       input logic [31:0] exp_data, input logic exp_err, input int lat);
        int n = 0;
        @(negedge Clk);
        while (!ReqReady && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!ReqReady) chk("ready_timeout", 32'd0, 32'd1);
        wr_cnt   = 0;
        rd_cnt   = 0;
        ReqValid = 1'b1;
        ReqWrite = w;
        ReqAddr  = a;
        ReqWData = d;
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        sb.push_back('{exp_data, exp_err, cyc + lat});
        wait_resp();
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ready"}, {31'd0, ReqReady}, 32'd1);
        chk({nm, "_resp"}, {30'd0, RespValid, RespErr}, 32'd0);
        chk({nm, "_rdata"}, RespData, 32'd0);
        chk({nm, "_en"}, {30'd0, MemReadEn, MemWriteEn}, 32'd0);
        chk({nm, "_pins"}, {12'd0, MemReadAddress, MemWriteAddress, MemWriteData}, 32'd0);
    endtask

    initial begin
        Reset    = 1'b1;
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        ReqAddr  = 6'd0;
        ReqWData = 32'd0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_idle_outputs("reset");
        Reset = 1'b0;

        // Store DEADBEEF at 0x08
        req(1'b1, 6'h08, 32'hDEADBEEF, 32'h0, 1'b0, 4);
        chk("st8_wr_cnt", wr_cnt, 4);
        chk("st8_rd_cnt", rd_cnt, 0);
        chk("st8_ram", {ram[8], ram[9], ram[10], ram[11]}, 32'hDEADBEEF);

        // Load back from 0x08
        req(1'b0, 6'h08, 32'h0, 32'hDEADBEEF, 1'b0, 4);
        chk("ld8_rd_cnt", rd_cnt, 4);
        chk("ld8_wr_cnt", wr_cnt, 0);

`ifndef RAM_CTRL_ALIGN_CHECK_EN
        // Address wrap 63 -> 0
        req(1'b1, 6'h3E, 32'h11223344, 32'hDEADBEEF, 1'b0, 4);
        chk("wrap_ram", {ram[62], ram[63], ram[0], ram[1]}, 32'h11223344);
        req(1'b0, 6'h3E, 32'h0, 32'h11223344, 1'b0, 4);

        // Misaligned address is a normal access
        req(1'b1, 6'h05, 32'hCAFEF00D, 32'h11223344, 1'b0, 4);
        chk("mis_st_wr_cnt", wr_cnt, 4);
        chk("mis_ram", {ram[5], ram[6], ram[7], ram[8]}, 32'hCAFEF00D);
        req(1'b0, 6'h05, 32'h0, 32'hCAFEF00D, 1'b0, 4);
        chk("mis_ld_rd_cnt", rd_cnt, 4);
`else
        // Misaligned address rejected with error, no RAM access
        req(1'b1, 6'h05, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1, 0);
        chk("mis_st_wr_cnt", wr_cnt, 0);
        chk("mis_ram", {ram[5], ram[6], ram[7], ram[8]}, 32'h000000DE);
        req(1'b0, 6'h05, 32'h0, 32'hDEADBEEF, 1'b1, 0);
        chk("mis_ld_rd_cnt", rd_cnt, 0);
`endif

        // Back-to-back with ReqValid held: store then load at 0x20
        @(negedge Clk);
        wr_cnt   = 0;
        rd_cnt   = 0;
        ReqValid = 1'b1;
        ReqWrite = 1'b1;
        ReqAddr  = 6'h20;
        ReqWData = 32'h55667788;
        @(posedge Clk);
        #1;
        acc1 = cyc;
`ifndef RAM_CTRL_ALIGN_CHECK_EN
        sb.push_back('{32'hCAFEF00D, 1'b0, acc1 + 4});
`else
        sb.push_back('{32'hDEADBEEF, 1'b0, acc1 + 4});
`endif
        ReqWrite = 1'b0;
        ReqWData = 32'h0;
        acc2 = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (ReqReady) begin
                acc2 = cyc + 1;
                break;
            end
        end
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        chk("b2b_accept_gap", acc2 - acc1, 6);
        sb.push_back('{32'h55667788, 1'b0, acc2 + 4});
        wait_resp();
        chk("b2b_wr_cnt", wr_cnt, 4);
        chk("b2b_rd_cnt", rd_cnt, 4);

        // Reset mid-store after XFER1
        @(negedge Clk);
        ReqValid = 1'b1;
        ReqWrite = 1'b1;
        ReqAddr  = 6'h10;
        ReqWData = 32'hA1B2C3D4;
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_in_xfer1", {26'd0, MemWriteAddress}, 32'h11);
        Reset = 1'b1;
        @(negedge Clk);
        chk_idle_outputs("abort");
        Reset = 1'b0;
        repeat (8) @(negedge Clk);

        // Controller works after the abort
        req(1'b1, 6'h10, 32'h0BADC0DE, 32'h0, 1'b0, 4);
        req(1'b0, 6'h10, 32'h0, 32'h0BADC0DE, 1'b0, 4);

        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
